// File: rtl/reg_load_sequencer_pkg.sv
// Shared definitions for the register load sequencer: FunSel codes, load modes, FSM states.
package reg_load_sequencer_pkg;

  localparam logic [2:0] FS_DEC     = 3'b000;
  localparam logic [2:0] FS_INC     = 3'b001;
  localparam logic [2:0] FS_LOAD    = 3'b010;
  localparam logic [2:0] FS_CLR     = 3'b011;
  localparam logic [2:0] FS_WLO_CLR = 3'b100;
  localparam logic [2:0] FS_WLO     = 3'b101;
  localparam logic [2:0] FS_WHI     = 3'b110;
  localparam logic [2:0] FS_SEXT    = 3'b111;

  localparam logic [1:0] MODE_WORD = 2'b00;
  localparam logic [1:0] MODE_ZEXT = 2'b01;
  localparam logic [1:0] MODE_SEXT = 2'b10;
  localparam logic [1:0] MODE_HI   = 2'b11;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StFetchLo = 2'd1,
    StFetchHi = 2'd2,
    StDone    = 2'd3
  } state_e;

  function automatic logic is_fetch(input state_e s);
    return (s == StFetchLo) || (s == StFetchHi);
  endfunction

endpackage

// File: rtl/reg_load_sequencer_wait_timer.sv
// Clear/increment wait counter with a match flag against a fixed compare value.
module reg_load_sequencer_wait_timer #(
  parameter int unsigned TW    = 8,
  parameter int unsigned MATCH = 254
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clr,
  input  logic i_inc,
  output logic o_match
);

  logic [TW-1:0] r_count;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_inc) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_match = (r_count == TW'(MATCH));

endmodule

// File: rtl/reg_load_sequencer.sv
// Assembles bytes from an 8-bit valid/ready memory port into FunSel register write strobes.
module reg_load_sequencer
  import reg_load_sequencer_pkg::*;
#(
  parameter int unsigned NUM_REGS = 4,
  parameter int unsigned TIMEOUT  = 255,
  parameter int unsigned TW       = 8,
  localparam int unsigned TgtW    = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_req,
  input  logic [1:0]          i_mode,
  input  logic [TgtW-1:0]     i_target,
  input  logic                i_abort,
  input  logic                i_byte_valid,
  input  logic [7:0]          i_byte_data,
  output logic                o_byte_ready,
  output logic [NUM_REGS-1:0] o_reg_e,
  output logic [2:0]          o_reg_fun_sel,
  output logic [15:0]         o_reg_i,
  output logic                o_busy,
  output logic                o_done,
  output logic                o_error
);

  localparam int unsigned TmrMatch = (TIMEOUT != 0) ? TIMEOUT - 1 : 0;

  state_e              r_state;
  state_e              w_state_next;
  logic [1:0]          r_mode;
  logic [TgtW-1:0]     r_target;
  logic                w_in_fetch;
  logic                w_accept;
  logic                w_timeout;
  logic                w_tmr_clr;
  logic                w_tmr_inc;
  logic                w_tmr_match;
  logic                w_strobe;
  logic [2:0]          w_fun_sel;
  logic                w_done_next;
  logic                w_error_next;
  logic [NUM_REGS-1:0] w_reg_e_sel;
  logic [NUM_REGS-1:0] r_reg_e;
  logic [2:0]          r_fun_sel;
  logic [15:0]         r_reg_i;
  logic                r_done;
  logic                r_error;

  assign w_in_fetch  = is_fetch(r_state);
  assign w_accept    = i_byte_valid & w_in_fetch;
  assign w_timeout   = (TIMEOUT != 0) && w_tmr_match && !w_accept;
  assign w_reg_e_sel = NUM_REGS'(1) << r_target;

  // Timer restarts on every accepted byte and whenever the next state leaves FETCH.
  assign w_tmr_clr = w_accept | !is_fetch(w_state_next);
  assign w_tmr_inc = w_in_fetch & !w_accept;

  reg_load_sequencer_wait_timer #(
    .TW    (TW),
    .MATCH (TmrMatch)
  ) u_wait_timer (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_clr   (w_tmr_clr),
    .i_inc   (w_tmr_inc),
    .o_match (w_tmr_match)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state  <= StIdle;
      r_mode   <= MODE_WORD;
      r_target <= '0;
    end else begin
      r_state <= w_state_next;
      if ((r_state == StIdle) && i_req) begin
        r_mode   <= i_mode;
        r_target <= i_target;
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_strobe     = 1'b0;
    w_fun_sel    = FS_DEC;
    w_done_next  = 1'b0;
    w_error_next = 1'b0;
    case (r_state)
      StIdle: begin
        if (i_req) begin
          w_state_next = (i_mode == MODE_HI) ? StFetchHi : StFetchLo;
        end
      end
      StFetchLo: begin
        // Abort outranks both a coincident accept and a timeout.
        if (i_abort) begin
          w_state_next = StIdle;
        end else if (w_accept) begin
          w_strobe = 1'b1;
          case (r_mode)
            MODE_WORD: begin
              w_fun_sel    = FS_WLO_CLR;
              w_state_next = StFetchHi;
            end
            MODE_ZEXT: begin
              w_fun_sel    = FS_WLO_CLR;
              w_state_next = StDone;
            end
            default: begin
              w_fun_sel    = FS_SEXT;
              w_state_next = StDone;
            end
          endcase
        end else if (w_timeout) begin
          w_state_next = StIdle;
          w_error_next = 1'b1;
        end
      end
      StFetchHi: begin
        if (i_abort) begin
          w_state_next = StIdle;
        end else if (w_accept) begin
          w_strobe     = 1'b1;
          w_fun_sel    = FS_WHI;
          w_state_next = StDone;
        end else if (w_timeout) begin
          w_state_next = StIdle;
          w_error_next = 1'b1;
        end
      end
      StDone: begin
        w_state_next = StIdle;
        w_done_next  = 1'b1;
      end
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_reg_e   <= '0;
      r_fun_sel <= '0;
      r_reg_i   <= '0;
      r_done    <= 1'b0;
      r_error   <= 1'b0;
    end else begin
      r_reg_e <= w_strobe ? w_reg_e_sel : '0;
      if (w_strobe) begin
        r_fun_sel <= w_fun_sel;
        r_reg_i   <= {8'h00, i_byte_data};
      end
      r_done  <= w_done_next;
      r_error <= w_error_next;
    end
  end

  assign o_byte_ready  = w_in_fetch;
  assign o_busy        = (r_state != StIdle);
  assign o_reg_e       = r_reg_e;
  assign o_reg_fun_sel = r_fun_sel;
  assign o_reg_i       = r_reg_i;
  assign o_done        = r_done;
  assign o_error       = r_error;

endmodule

// File: tb/tb_reg_load_sequencer.sv
// Scoreboard bench: stimulus queues expected strobe/Done/Error events with cycle stamps.
module tb_reg_load_sequencer;

  logic        clk;
  logic        rst_n;
  logic        req;
  logic [1:0]  mode;
  logic [1:0]  target;
  logic        abort;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic [3:0]  reg_e;
  logic [2:0]  reg_fun_sel;
  logic [15:0] reg_i;
  logic        busy;
  logic        done;
  logic        error;

  typedef struct {
    logic [3:0]  e;
    logic [2:0]  fs;
    logic [15:0] d;
    logic        done;
    logic        err;
    int          cyc;
  } ev_t;

  ev_t         exp_q[$];
  logic [15:0] model [4];
  int          cyc;
  int          n_checks;
  int          n_pass;

  reg_load_sequencer #(
    .NUM_REGS (4),
    .TIMEOUT  (4),
    .TW       (8)
  ) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_req         (req),
    .i_mode        (mode),
    .i_target      (target),
    .i_abort       (abort),
    .i_byte_valid  (byte_valid),
    .i_byte_data   (byte_data),
    .o_byte_ready  (byte_ready),
    .o_reg_e       (reg_e),
    .o_reg_fun_sel (reg_fun_sel),
    .o_reg_i       (reg_i),
    .o_busy        (busy),
    .o_done        (done),
    .o_error       (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Monitor: every visible strobe/Done/Error must match the head of the queue.
  always @(negedge clk) begin
    ev_t x;
    if (rst_n && (reg_e != 4'b0 || done || error)) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL unexpected_event: got e=%b fs=%b d=%h done=%b err=%b cyc=%0d expected none",
                 reg_e, reg_fun_sel, reg_i, done, error, cyc);
      end else begin
        x = exp_q.pop_front();
        if (reg_e == x.e && done == x.done && error == x.err && cyc == x.cyc &&
            (reg_e == 4'b0 || (reg_fun_sel == x.fs && reg_i == x.d))) begin
          n_pass++;
        end else begin
          $display("FAIL event: got e=%b fs=%b d=%h done=%b err=%b cyc=%0d expected e=%b fs=%b d=%h done=%b err=%b cyc=%0d",
                   reg_e, reg_fun_sel, reg_i, done, error, cyc,
                   x.e, x.fs, x.d, x.done, x.err, x.cyc);
        end
      end
      for (int i = 0; i < 4; i++) begin
        if (reg_e[i]) begin
          case (reg_fun_sel)
            3'b100:  model[i] = {8'h00, reg_i[7:0]};
            3'b110:  model[i] = {reg_i[7:0], model[i][7:0]};
            3'b111:  model[i] = {{8{reg_i[7]}}, reg_i[7:0]};
            default: ;
          endcase
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [3:0] e, input logic [2:0] fs, input logic [15:0] d,
                      input logic dn, input logic er, input int c);
    ev_t x;
    x.e = e; x.fs = fs; x.d = d; x.done = dn; x.err = er; x.cyc = c;
    exp_q.push_back(x);
  endtask

  task automatic start(input logic [1:0] m, input logic [1:0] t);
    mode = m; target = t; req = 1'b1;
    tick();
    req = 1'b0;
  endtask

  // Offer one byte in the current cycle; strobe expected next cycle, Done one after if last.
  task automatic offer(input logic [7:0] b, input logic [3:0] e, input logic [2:0] fs,
                       input logic last);
    chk("ready_on_offer", {31'b0, byte_ready}, 32'd1);
    push(e, fs, {8'h00, b}, 1'b0, 1'b0, cyc + 1);
    if (last) push(4'b0, 3'b0, 16'h0, 1'b1, 1'b0, cyc + 2);
    byte_valid = 1'b1; byte_data = b;
    tick();
    byte_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    repeat (4) tick();
    chk(name, exp_q.size(), 32'd0);
    chk("idle_after", {31'b0, busy}, 32'd0);
  endtask

  initial begin
    int rdy_cnt;
    cyc = 0; n_checks = 0; n_pass = 0;
    rst_n = 1'b0; req = 1'b0; mode = 2'b00; target = 2'b00; abort = 1'b0;
    byte_valid = 1'b0; byte_data = 8'h00;
    for (int i = 0; i < 4; i++) model[i] = 16'h0000;
    repeat (3) tick();
    chk("rst_reg_e", {28'b0, reg_e}, 32'd0);
    chk("rst_fun_sel", {29'b0, reg_fun_sel}, 32'd0);
    chk("rst_reg_i", {16'b0, reg_i}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_ready", {31'b0, byte_ready}, 32'd0);
    chk("rst_done_err", {30'b0, done, error}, 32'd0);
    rst_n = 1'b1;
    tick();

    // 1: word to reg 2, back-to-back bytes
    start(2'b00, 2'd2);
    chk("busy_after_req", {31'b0, busy}, 32'd1);
    offer(8'h34, 4'b0100, 3'b100, 1'b0);
    offer(8'h12, 4'b0100, 3'b110, 1'b1);
    chk("busy_in_done", {31'b0, busy}, 32'd1);
    drain("t1_queue");
    chk("t1_reg2", {16'b0, model[2]}, 32'h1234);

    // 2: sign-extend then zero-extend into reg 0
    start(2'b10, 2'd0);
    offer(8'h85, 4'b0001, 3'b111, 1'b1);
    drain("t2s_queue");
    chk("t2_sext", {16'b0, model[0]}, 32'hFF85);
    start(2'b01, 2'd0);
    offer(8'h85, 4'b0001, 3'b100, 1'b1);
    drain("t2z_queue");
    chk("t2_zext", {16'b0, model[0]}, 32'h0085);

    // 3: high byte only into reg 1 holding 0xAAAA
    model[1] = 16'hAAAA;
    start(2'b11, 2'd1);
    offer(8'h5C, 4'b0010, 3'b110, 1'b1);
    drain("t3_queue");
    chk("t3_reg1", {16'b0, model[1]}, 32'h5CAA);

    // 4: timeout with no bytes; ready for exactly 4 cycles, one Error
    start(2'b00, 2'd2);
    push(4'b0, 3'b0, 16'h0, 1'b0, 1'b1, cyc + 4);
    rdy_cnt = 0;
    for (int i = 0; i < 7; i++) begin
      if (byte_ready) rdy_cnt++;
      tick();
    end
    chk("t4_ready_cycles", rdy_cnt, 32'd4);
    drain("t4_queue");
    chk("t4_reg2_kept", {16'b0, model[2]}, 32'h1234);

    // Gap boundary: byte arrives on the last allowed cycle (timer at TIMEOUT-1)
    start(2'b00, 2'd3);
    repeat (3) tick();
    offer(8'hCD, 4'b1000, 3'b100, 1'b0);
    repeat (3) tick();
    offer(8'hAB, 4'b1000, 3'b110, 1'b1);
    drain("gap_queue");
    chk("gap_reg3", {16'b0, model[3]}, 32'hABCD);

    // 5: abort after low byte; Req in FETCH_HI ignored; abort beats coincident byte
    start(2'b00, 2'd3);
    offer(8'h77, 4'b1000, 3'b100, 1'b0);
    mode = 2'b01; target = 2'd0; req = 1'b1;
    tick();
    req = 1'b0;
    abort = 1'b1; byte_valid = 1'b1; byte_data = 8'hEE;
    tick();
    abort = 1'b0; byte_valid = 1'b0;
    chk("t5_ready_off", {31'b0, byte_ready}, 32'd0);
    drain("t5_queue");
    chk("t5_reg3", {16'b0, model[3]}, 32'h0077);

    // 6: reset in the strobe cycle after a low-byte accept
    start(2'b00, 2'd1);
    chk("t6_ready", {31'b0, byte_ready}, 32'd1);
    byte_valid = 1'b1; byte_data = 8'h9A;
    tick();
    byte_valid = 1'b0;
    chk("t6_strobe_seen", {28'b0, reg_e}, 32'b0010);
    rst_n = 1'b0;
    #1;
    chk("t6_reg_e", {28'b0, reg_e}, 32'd0);
    chk("t6_outs", {16'b0, reg_i}, 32'd0);
    chk("t6_flags", {26'b0, reg_fun_sel, busy, done, error}, 32'd0);
    chk("t6_ready_off", {31'b0, byte_ready}, 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    chk("t6_reg1_kept", {16'b0, model[1]}, 32'h5CAA);
    start(2'b00, 2'd1);
    offer(8'h78, 4'b0010, 3'b100, 1'b0);
    offer(8'h56, 4'b0010, 3'b110, 1'b1);
    drain("t6_queue");
    chk("t6_reg1", {16'b0, model[1]}, 32'h5678);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
